// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks: frame data width and the transmit
// state encoding.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

endpackage : uart_pkg

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period counter. Counts 0..CLKS_PER_BIT-1 and pulses tick on the terminal
// count, then wraps to 0, so every bit lasts exactly CLKS_PER_BIT cycles.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   clear  - synchronous clear; holds the counter at 0 and suppresses tick
//   tick   - high during the last cycle of each bit period
// -----------------------------------------------------------------------------
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the processes are evaluated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !clear && (cnt == LAST);

endmodule : uart_baud_gen

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Byte-wide UART transmitter draining an upstream fifo through a valid/ready
// handshake. Frames are start bit, 8 data bits LSB first, optional even parity,
// then 1 or 2 stop bits.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   in_data  - byte to send, sampled only on the accepting edge
//   in_valid - upstream has a byte
//   in_ready - high only in IDLE; a byte is accepted when in_valid && in_ready
//   tx       - registered serial line, idles high
//   busy     - a frame is in progress
// -----------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [UART_DATA_BITS-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      tx,
  output logic                      busy
);

  localparam logic [2:0] LAST_DATA_BIT = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP_BIT = 3'(STOP_BITS - 1);

  uart_state_t               state_q, state_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic                      parity_q, parity_d;
  logic                      tx_q, tx_d;
  logic                      tick;

  // The baud counter is held cleared while idle, so it starts from 0 on the
  // acceptance edge and the start bit gets a full period.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(state_q == IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d   = in_data;
          parity_d  = ^in_data;
          bit_cnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LAST_DATA_BIT) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (tick) state_d = STOP;
      end
      STOP: begin
        // The bit counter, back at 0 after the data bits, counts stop bits.
        if (tick) begin
          if (bit_cnt_q == LAST_STOP_BIT) begin
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The line level is derived from the next state and registered, so tx
  // changes on the same edge as the state and is glitch-free at the pin.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign tx       = tx_q;
  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Three transmitters (8N1, 8E1, 8N2) at 4 clocks per bit, fed from a small
// fifo model. Expected line levels are queued per cycle when a byte is
// accepted and popped as the line is sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int CPB    = 4;
  localparam int BUDGET = 300;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic [2:0] in_valid;
  wire  [2:0] tx;
  wire  [2:0] in_ready;
  wire  [2:0] busy;

  always #10 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut_8n1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .tx(tx[0]), .busy(busy[0])
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) dut_8e1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .tx(tx[1]), .busy(busy[1])
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(2)) dut_8n2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .tx(tx[2]), .busy(busy[2])
  );

  int   checks = 0;
  int   errors = 0;
  logic [7:0] fifo_q[$];
  logic       exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Queue the per-cycle line levels of one frame for the selected transmitter.
  task automatic push_frame(input int sel, input logic [7:0] b);
    int stops;
    stops = (sel == 2) ? 2 : 1;
    repeat (CPB) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (CPB) exp_q.push_back(b[i]);
    if (sel == 1) repeat (CPB) exp_q.push_back(^b);
    repeat (stops * CPB) exp_q.push_back(1'b1);
  endtask

  // Drain fifo_q into transmitter sel, checking the line every cycle until the
  // fifo is empty and the transmitter has returned to idle.
  task automatic run(input int sel, input string tag);
    int   cyc;
    logic acc;
    logic e;
    logic [7:0] b;
    cyc = 0;
    forever begin
      in_valid[sel] = (fifo_q.size() != 0);
      in_data       = (fifo_q.size() != 0) ? fifo_q[0] : 8'($urandom);
      #1;
      acc = in_valid[sel] && in_ready[sel];
      @(posedge clk);
      #1;
      if (acc) begin
        b = fifo_q.pop_front();
        push_frame(sel, b);
        in_data = 8'($urandom);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check({tag, " tx"}, 32'(tx[sel]), 32'(e));
        check({tag, " in_ready low"}, 32'(in_ready[sel]), 32'd0);
        check({tag, " busy high"}, 32'(busy[sel]), 32'd1);
      end else begin
        check({tag, " idle tx"}, 32'(tx[sel]), 32'd1);
        check({tag, " idle in_ready"}, 32'(in_ready[sel]), 32'd1);
        check({tag, " idle busy"}, 32'(busy[sel]), 32'd0);
        if (fifo_q.size() == 0) break;
      end
      cyc++;
      if (cyc > BUDGET) begin
        checks++;
        errors++;
        $error("FAIL %s timeout: cycles %0d budget %0d", tag, cyc, BUDGET);
        break;
      end
    end
    in_valid[sel] = 1'b0;
    exp_q.delete();
    fifo_q.delete();
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = '0;
    in_data  = '0;

    // Reset: outputs must be at rest during and after reset.
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("in reset tx[%0d]", s), 32'(tx[s]), 32'd1);
      check($sformatf("in reset in_ready[%0d]", s), 32'(in_ready[s]), 32'd1);
    end
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("reset tx[%0d]", s), 32'(tx[s]), 32'd1);
      check($sformatf("reset in_ready[%0d]", s), 32'(in_ready[s]), 32'd1);
      check($sformatf("reset busy[%0d]", s), 32'(busy[s]), 32'd0);
    end

    // Single 0xA5 frame, 8N1.
    fifo_q.push_back(8'hA5);
    run(0, "8n1 a5");

    // Even parity: 0xA5 gives parity 0, 0x07 gives parity 1, back-to-back.
    fifo_q.push_back(8'hA5);
    fifo_q.push_back(8'h07);
    run(1, "8e1 a5 07");

    // Back-to-back from a fifo holding two bytes.
    fifo_q.push_back(8'hFE);
    fifo_q.push_back(8'hED);
    run(0, "8n1 fe ed");

    // Reset during data bit 3 of 0x55 (bit 3 is 0, so the line must rise).
    in_data     = 8'h55;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    in_data     = 8'h00;
    repeat (17) @(posedge clk);
    #1;
    check("mid frame tx bit3", 32'(tx[0]), 32'd0);
    check("mid frame busy", 32'(busy[0]), 32'd1);
    #4 rst_n = 1'b0;
    #1;
    check("async reset tx", 32'(tx[0]), 32'd1);
    check("async reset busy", 32'(busy[0]), 32'd0);
    check("async reset in_ready", 32'(in_ready[0]), 32'd1);
    @(posedge clk);
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("after reset tx", 32'(tx[0]), 32'd1);
    check("after reset in_ready", 32'(in_ready[0]), 32'd1);
    fifo_q.push_back(8'h3C);
    run(0, "8n1 3c after reset");

    // Two stop bits: 44-cycle frame, next start no earlier than cycle 45.
    fifo_q.push_back(8'hA5);
    fifo_q.push_back(8'h3C);
    run(2, "8n2 a5 3c");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_uart_tx
